// File: rtl/synch_fifo_param.sv
// Parametrised single-clock FIFO with watermarks, sticky error flags and occupancy count.
// Define SYNCH_FIFO_FWFT_EN for first-word-fall-through reads (head word shown combinationally).
module synch_fifo_param #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        read_data,
  output logic                     full,
  output logic                     empty,
  output logic                     full_nxt,
  output logic                     empty_nxt,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   data_avail,
  output logic [$clog2(DEPTH):0]   room_avail,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("synch_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("synch_fifo_param: AF_LEVEL must not exceed DEPTH");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
    $error("synch_fifo_param: AE_LEVEL must be below AF_LEVEL");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc, rd_acc;

  always_comb begin
    // A write into a full FIFO is only safe when the same edge pops a word.
    wr_acc   = wr_en & (~full_q | rd_en);
    rd_acc   = rd_en & ~empty_q;
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PW'(rd_acc);
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    // New errors take priority over a simultaneous clear.
    ovf_d = clr_err ? 1'b0 : ovf_q;
    if (wr_en & ~wr_acc) ovf_d = 1'b1;
    unf_d = clr_err ? 1'b0 : unf_q;
    if (rd_en & empty_q) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem[wr_ptr_q] <= write_data;
  end

`ifdef SYNCH_FIFO_FWFT_EN
  assign read_data = mem[rd_ptr_q];
`else
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) rdata_d = mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign read_data = rdata_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign full_nxt     = full_d;
  assign empty_nxt    = empty_d;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign data_avail   = count_q;
  assign room_avail   = DEPTH_C - count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_synch_fifo_param.sv
// Directed bench for synch_fifo_param (DATA_W=16, DEPTH=8, AF=6, AE=2); honours SYNCH_FIFO_FWFT_EN.
module tb_synch_fifo_param;

  logic        clk = 1'b0;
  logic        reset, wr_en, rd_en, clr_err;
  logic [15:0] write_data, read_data;
  logic        full, empty, full_nxt, empty_nxt, almost_full, almost_empty;
  logic [3:0]  data_avail, room_avail;
  logic        overflow, underflow;

  int checks = 0;
  int errors = 0;
  logic chk_nxt = 1'b0;

  synch_fifo_param #(.DATA_W(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .write_data(write_data),
    .rd_en(rd_en), .clr_err(clr_err), .read_data(read_data),
    .full(full), .empty(empty), .full_nxt(full_nxt), .empty_nxt(empty_nxt),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .data_avail(data_avail), .room_avail(room_avail),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic fn, en;
    @(negedge clk);
    fn = full_nxt;
    en = empty_nxt;
    @(posedge clk);
    #1;
    if (chk_nxt) begin
      chk("full_nxt", 32'(full), 32'(fn));
      chk("empty_nxt", 32'(empty), 32'(en));
    end
  endtask

  // One cycle of traffic; chk_rd compares the word the pop delivers.
  task automatic cyc(input logic w, input logic r, input logic [15:0] wd,
                     input logic chk_rd, input logic [15:0] exp);
    wr_en = w;
    rd_en = r;
    write_data = wd;
`ifdef SYNCH_FIFO_FWFT_EN
    #0;
    if (chk_rd) chk("read_data", 32'(read_data), 32'(exp));
    tick();
`else
    tick();
    if (chk_rd) chk("read_data", 32'(read_data), 32'(exp));
`endif
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; write_data = '0;

    // 1: reset and idle
    do_reset();
    tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_avail", 32'(data_avail), 32'd0);
    chk("rst_room", 32'(room_avail), 32'd8);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
`ifndef SYNCH_FIFO_FWFT_EN
    chk("rst_rdata", 32'(read_data), 32'h0000);
`endif

    // 2: write 9 words, the last one overflows
    chk_nxt = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, 1'b0, 16'hFFFF - 16'(i), 1'b0, 16'h0);
      chk("wr_avail", 32'(data_avail), (i <= 8) ? 32'(i) : 32'd8);
      chk("wr_room", 32'(room_avail), (i <= 8) ? 32'(8 - i) : 32'd0);
      chk("wr_full", 32'(full), (i >= 8) ? 32'd1 : 32'd0);
      chk("wr_af", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
      chk("wr_ae", 32'(almost_empty), (i <= 2) ? 32'd1 : 32'd0);
      chk("wr_ovf", 32'(overflow), (i == 9) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, 16'h0, 1'b1, 16'hFFFE - 16'(k));
      chk("rd_avail", 32'(data_avail), 32'(7 - k));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // 3: reads on an empty FIFO
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'b1, 16'h0, 1'b0, 16'h0);
    chk("unf_empty", 32'(empty), 32'd1);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_avail", 32'(data_avail), 32'd0);
`ifndef SYNCH_FIFO_FWFT_EN
    chk("unf_hold", 32'(read_data), 32'hFFF7);
`endif
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_unf", 32'(underflow), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);

    // 4: full with simultaneous read/write, pointers wrap
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 16'hB000 + 16'(i), 1'b0, 16'h0);
    chk("fill_full", 32'(full), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, 16'hA000 + 16'(k), 1'b1, 16'hB000 + 16'(k));
      chk("rw_full", 32'(full), 32'd1);
      chk("rw_avail", 32'(data_avail), 32'd8);
      chk("rw_ovf", 32'(overflow), 32'd0);
    end
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 16'h0, 1'b1, 16'hB004 + 16'(k));
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 16'h0, 1'b1, 16'hA000 + 16'(k));
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_unf", 32'(underflow), 32'd0);

    // 5: empty with simultaneous read/write
    cyc(1'b1, 1'b1, 16'h1234, 1'b0, 16'h0);
    chk("erw_avail", 32'(data_avail), 32'd1);
    chk("erw_unf", 32'(underflow), 32'd1);
    chk("erw_empty", 32'(empty), 32'd0);
    cyc(1'b0, 1'b1, 16'h0, 1'b1, 16'h1234);
    chk("erw_drain", 32'(empty), 32'd1);
    chk_nxt = 1'b0;

    // 6: head visibility and reset mid-fill
    do_reset();
    cyc(1'b1, 1'b0, 16'h5A5A, 1'b0, 16'h0);
    chk("head_empty", 32'(empty), 32'd0);
`ifdef SYNCH_FIFO_FWFT_EN
    chk("fwft_head", 32'(read_data), 32'h5A5A);
`endif
    cyc(1'b0, 1'b1, 16'h0, 1'b1, 16'h5A5A);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'hD000 + 16'(i), 1'b0, 16'h0);
    chk("mid_avail", 32'(data_avail), 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_avail", 32'(data_avail), 32'd0);
    cyc(1'b1, 1'b0, 16'hC0DE, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 16'h0, 1'b1, 16'hC0DE);
    chk("mid_rst_final", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
